csr_regfile: RTL and testbench
==============================

Name: csr_regfile

Overview:
- Machine-mode CSR storage for the RV64 core; sits directly downstream of the CSR ALU.
- Accepts the CSR ALU's `csr_write` value as write data and returns `csr_read` for the same instruction.
- Also performs the state update for ecall/mret and issues a registered PC redirect to fetch.
- Hosts the mcycle/minstret counters.

Parameters:
- XLEN, 64, CSR and PC data width
- MTVEC_RESET, 64'h0, reset value of mtvec (bits[1:0] forced 0)
- ECALL_CAUSE, 64'd11, mcause value written on ecall (environment call from M-mode)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  asynchronous active-low reset
- csr_addr  in  12  CSR address (inst[31:20])
- csr_we  in  1  write enable for the current CSR instruction
- csr_wdata  in  XLEN  write data (CSR ALU output)
- csr_rdata  out  XLEN  combinational read of csr_addr
- illegal_csr  out  1  combinational; high when csr_we or a read targets an unimplemented address
- trap_ecall  in  1  ecall in the commit stage
- trap_pc  in  XLEN  PC of the ecall instruction
- mret  in  1  mret in the commit stage
- inst_retire  in  1  one instruction retired this cycle
- stall  in  1  commit stage stalled; blocks all architectural updates except mcycle
- redirect_valid  out  1  registered one-cycle pulse: fetch must jump
- redirect_pc  out  XLEN  registered jump target, valid with redirect_valid

Behaviour:
- Implemented CSRs and reset values:
  - mstatus 0x300: reset 0x1800
  - mie 0x304: reset 0
  - mtvec 0x305: reset MTVEC_RESET & ~3
  - mscratch 0x340: reset 0
  - mepc 0x341: reset 0
  - mcause 0x342: reset 0
  - mtval 0x343: reset 0
  - mip 0x344: read-only 0
  - mcycle 0xB00 / minstret 0xB02: reset 0, counters
- All other addresses read 0 and assert illegal_csr; writes to them are dropped.
- Outputs at reset: redirect_valid=0, redirect_pc=0.
- Read path:
  - csr_rdata is combinational and returns the pre-write value.
  - A write at edge N is visible in csr_rdata after edge N.
- Write masks:
  - mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] is hardwired 2'b11; all other bits read 0.
  - mtvec and mepc: bits[1:0] forced 0 (direct mode, no compressed ISA).
  - mip: writes ignored, illegal_csr stays 0.
- Update priority per cycle, when stall=0:
  1. trap_ecall:
     - mepc<=trap_pc&~3, mcause<=ECALL_CAUSE, mtval<=0.
     - MPIE<=MIE, MIE<=0.
     - Next cycle: redirect_valid=1, redirect_pc=mtvec.
  2. mret:
     - MIE<=MPIE, MPIE<=1.
     - Next cycle: redirect_valid=1, redirect_pc=mepc (value before this edge).
  3. csr_we: write csr_wdata to csr_addr.
- Only the highest-priority event takes effect; the lower-priority events in that cycle are discarded.
- stall=1: trap_ecall, mret, csr_we and inst_retire are ignored; redirect_valid is 0 next cycle.
- redirect_valid is a single-cycle pulse. Back-to-back events on consecutive cycles each produce their own pulse.
- Counters:
  - mcycle increments every cycle, including during stall.
  - minstret increments when inst_retire=1 and stall=0.
  - Both wrap 0xFFFF_FFFF_FFFF_FFFF -> 0.
  - A csr_we to a counter in the same cycle loads csr_wdata and suppresses that cycle's increment.
  - A counter write is discarded if trap_ecall or mret wins the cycle (increment still applies).
- Reset mid-operation: rstn low asynchronously clears all state including a pending redirect; no redirect pulse follows reset release.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
- Defined: mcycle/minstret implemented as above.
- Undefined:
  - Counter registers are absent.
  - Reads of 0xB00/0xB02 return 0 with illegal_csr=0.
  - Writes to them are dropped.

Test Plan:
- Reset: rstn low then high.
  - Expect mstatus=0x1800, mtvec=MTVEC_RESET&~3, all other CSRs 0, redirect_valid=0.
- Write mtvec=0x8000_0103, then ecall with trap_pc=0x8000_0040 and MIE=1:
  - Next cycle: redirect_valid=1, redirect_pc=0x8000_0100.
  - After: mepc=0x8000_0040, mcause=11, mstatus=0x1880.
- From that state, mret:
  - Next cycle: redirect_pc=0x8000_0040.
  - mstatus=0x1888 (MIE=1, MPIE=1).
- Same cycle trap_ecall=1 and csr_we=1 to mscratch with 0xDEAD:
  - mscratch unchanged.
  - Trap performed.
- Write 0xFFFF_FFFF_FFFF_FFFF to minstret, then retire one instruction:
  - minstret=0.
  - In the same cycle as the write, mcycle still increments and minstret does not.
- csr_we to 0x7C0 with 0x55:
  - illegal_csr=1, read returns 0.
  - With stall=1, an ecall produces no redirect and mepc is unchanged.

Source files
------------

// File: rtl/csr_regfile_if.sv
// CSR port bundle between the commit stage (master) and the machine-mode CSR file (slave).
interface csr_regfile_if #(
  parameter int XLEN = 64
);
  logic [11:0]     csr_addr;
  logic            csr_we;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            illegal_csr;
  logic            trap_ecall;
  logic [XLEN-1:0] trap_pc;
  logic            mret;
  logic            inst_retire;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport slave (
    input  csr_addr, csr_we, csr_wdata, trap_ecall, trap_pc, mret, inst_retire, stall,
    output csr_rdata, illegal_csr, redirect_valid, redirect_pc
  );

  modport master (
    output csr_addr, csr_we, csr_wdata, trap_ecall, trap_pc, mret, inst_retire, stall,
    input  csr_rdata, illegal_csr, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_regfile.sv
// RV64 machine-mode CSR file with ecall/mret state update and registered fetch redirect.
// Define CSR_COUNTERS_EN to implement mcycle/minstret; otherwise those addresses read 0.
module csr_regfile #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(11)
) (
  input  logic         clk,
  input  logic         rstn,
  csr_regfile_if.slave bus
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;

  logic            st_mie_q, st_mpie_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] rdata;
  logic            illegal;

  // One event per cycle: ecall beats mret beats a CSR write; stall blocks all three.
  logic ev_ecall, ev_mret, ev_we;
  assign ev_ecall = !bus.stall && bus.trap_ecall;
  assign ev_mret  = !bus.stall && !bus.trap_ecall && bus.mret;
  assign ev_we    = !bus.stall && !bus.trap_ecall && !bus.mret && bus.csr_we;

`ifdef CSR_COUNTERS_EN
  logic [XLEN-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

  // A winning write loads the counter and replaces that cycle's increment.
  always_comb begin
    mcycle_d   = mcycle_q + XLEN'(1);
    minstret_d = minstret_q + XLEN'(bus.inst_retire && !bus.stall);
    if (ev_we && bus.csr_addr == A_MCYCLE)   mcycle_d   = bus.csr_wdata;
    if (ev_we && bus.csr_addr == A_MINSTRET) minstret_d = bus.csr_wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = bus.inst_retire;
`endif

  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = st_mpie_q;
    mstatus_rd[3]     = st_mie_q;
  end

  always_comb begin
    rdata   = '0;
    illegal = 1'b0;
    case (bus.csr_addr)
      A_MSTATUS:  rdata = mstatus_rd;
      A_MIE:      rdata = mie_q;
      A_MTVEC:    rdata = mtvec_q;
      A_MSCRATCH: rdata = mscratch_q;
      A_MEPC:     rdata = mepc_q;
      A_MCAUSE:   rdata = mcause_q;
      A_MTVAL:    rdata = mtval_q;
      A_MIP:      rdata = '0;
`ifdef CSR_COUNTERS_EN
      A_MCYCLE:   rdata = mcycle_q;
      A_MINSTRET: rdata = minstret_q;
`else
      A_MCYCLE, A_MINSTRET: rdata = '0;
`endif
      default:    illegal = 1'b1;
    endcase
  end

  assign bus.csr_rdata      = rdata;
  assign bus.illegal_csr    = illegal;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_mie_q         <= 1'b0;
      st_mpie_q        <= 1'b0;
      mie_q            <= '0;
      mtvec_q          <= {MTVEC_RESET[XLEN-1:2], 2'b00};
      mscratch_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= ev_ecall || ev_mret;
      if (ev_ecall) begin
        mepc_q        <= {bus.trap_pc[XLEN-1:2], 2'b00};
        mcause_q      <= ECALL_CAUSE;
        mtval_q       <= '0;
        st_mpie_q     <= st_mie_q;
        st_mie_q      <= 1'b0;
        redirect_pc_q <= mtvec_q;
      end else if (ev_mret) begin
        st_mie_q      <= st_mpie_q;
        st_mpie_q     <= 1'b1;
        redirect_pc_q <= mepc_q;
      end else if (ev_we) begin
        case (bus.csr_addr)
          A_MSTATUS: begin
            st_mie_q  <= bus.csr_wdata[3];
            st_mpie_q <= bus.csr_wdata[7];
          end
          A_MIE:      mie_q      <= bus.csr_wdata;
          A_MTVEC:    mtvec_q    <= {bus.csr_wdata[XLEN-1:2], 2'b00};
          A_MSCRATCH: mscratch_q <= bus.csr_wdata;
          A_MEPC:     mepc_q     <= {bus.csr_wdata[XLEN-1:2], 2'b00};
          A_MCAUSE:   mcause_q   <= bus.csr_wdata;
          A_MTVAL:    mtval_q    <= bus.csr_wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Scoreboarded bench for csr_regfile: stimulus queues expected reads and redirects, monitor checks them.
module tb_csr_regfile;
  localparam int          XLEN = 64;
  localparam logic [63:0] MTV  = 64'h1237;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  csr_regfile_if #(.XLEN(XLEN)) bus ();

  csr_regfile #(.XLEN(XLEN), .MTVEC_RESET(MTV), .ECALL_CAUSE(64'd11)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct { logic v; logic [63:0] pc; } rv_t;
  typedef struct { logic [11:0] a; logic [63:0] d; logic ill; } rd_t;
  rv_t  rvq[$];
  rd_t  rdq[$];
  logic rd_chk = 1'b0;
  int   tests = 0;
  int   fails = 0;

  task automatic idle_inputs();
    bus.csr_addr = '0; bus.csr_we = 1'b0; bus.csr_wdata = '0;
    bus.trap_ecall = 1'b0; bus.trap_pc = '0; bus.mret = 1'b0;
    bus.inst_retire = 1'b0; bus.stall = 1'b0;
    rd_chk = 1'b0;
  endtask

  // One commit cycle; rv_exp/rpc_exp describe the redirect expected in the following cycle.
  task automatic cyc(input logic [11:0] a, input logic we, input logic [63:0] wd,
                     input logic ec, input logic [63:0] tpc, input logic mr,
                     input logic ret, input logic st,
                     input logic rd_en, input logic [63:0] rd_exp, input logic ill_exp,
                     input logic rv_exp, input logic [63:0] rpc_exp);
    rv_t r;
    rd_t q;
    bus.csr_addr = a; bus.csr_we = we; bus.csr_wdata = wd;
    bus.trap_ecall = ec; bus.trap_pc = tpc; bus.mret = mr;
    bus.inst_retire = ret; bus.stall = st;
    r.v = rv_exp; r.pc = rpc_exp;
    rvq.push_back(r);
    if (rd_en) begin
      q.a = a; q.d = rd_exp; q.ill = ill_exp;
      rdq.push_back(q);
    end
    rd_chk = rd_en;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic rd(input logic [11:0] a, input logic [63:0] e, input logic ill);
    cyc(a, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, e, ill, 1'b0, '0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    cyc(a, 1'b1, d, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic idle();
    cyc('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  always @(negedge clk) begin
    if (rvq.size() > 0) begin
      rv_t e;
      e = rvq.pop_front();
      tests++;
      if (bus.redirect_valid !== e.v || (e.v && bus.redirect_pc !== e.pc)) begin
        fails++;
        $display("FAIL redirect @%0t: got v=%b pc=%h, want v=%b pc=%h",
                 $time, bus.redirect_valid, bus.redirect_pc, e.v, e.pc);
      end
    end
    if (rd_chk) begin
      tests++;
      if (rdq.size() == 0) begin
        fails++;
        $display("FAIL rdq_empty @%0t: read check with no expectation", $time);
      end else begin
        rd_t q;
        q = rdq.pop_front();
        if (bus.csr_rdata !== q.d || bus.illegal_csr !== q.ill) begin
          fails++;
          $display("FAIL read[%h] @%0t: got %h ill=%b, want %h ill=%b",
                   q.a, $time, bus.csr_rdata, bus.illegal_csr, q.d, q.ill);
        end
      end
    end
  end

  initial begin
    rv_t r0;
    idle_inputs();
    #23 rstn = 1'b1;
    @(posedge clk); #1;
    r0.v = 1'b0; r0.pc = '0;
    rvq.push_back(r0);

    // Reset values
    rd(12'h300, 64'h1800, 1'b0);
    rd(12'h304, 64'h0, 1'b0);
    rd(12'h305, 64'h1234, 1'b0);
    rd(12'h340, 64'h0, 1'b0);
    rd(12'h341, 64'h0, 1'b0);
    rd(12'h342, 64'h0, 1'b0);
    rd(12'h343, 64'h0, 1'b0);
    rd(12'h344, 64'h0, 1'b0);

    // Trap entry
    wr(12'h305, 64'h8000_0103);
    wr(12'h300, 64'h8);
    rd(12'h300, 64'h1808, 1'b0);
    rd(12'h305, 64'h8000_0100, 1'b0);
    cyc('0, 1'b0, '0, 1'b1, 64'h8000_0040, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 64'h8000_0100);
    rd(12'h341, 64'h8000_0040, 1'b0);
    rd(12'h342, 64'd11, 1'b0);
    rd(12'h343, 64'h0, 1'b0);
    rd(12'h300, 64'h1880, 1'b0);

    // Trap return
    cyc('0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 64'h8000_0040);
    rd(12'h300, 64'h1888, 1'b0);

    // ecall beats a same-cycle write
    cyc(12'h340, 1'b1, 64'hDEAD, 1'b1, 64'h8000_0203, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 64'h8000_0100);
    rd(12'h340, 64'h0, 1'b0);
    rd(12'h341, 64'h8000_0200, 1'b0);
    rd(12'h300, 64'h1880, 1'b0);

    // Back-to-back ecall then mret (mret also beats a write)
    cyc('0, 1'b0, '0, 1'b1, 64'h100, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 64'h8000_0100);
    cyc(12'h340, 1'b1, 64'h77, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 64'h100);
    rd(12'h340, 64'h0, 1'b0);
    rd(12'h300, 64'h1880, 1'b0);

    // Write masks
    wr(12'h300, ONES);
    rd(12'h300, 64'h1888, 1'b0);
    wr(12'h341, 64'h1234_5677);
    rd(12'h341, 64'h1234_5674, 1'b0);
    wr(12'h344, 64'hFF);
    rd(12'h344, 64'h0, 1'b0);

    // Unimplemented address
    cyc(12'h7C0, 1'b1, 64'h55, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, '0);
    rd(12'h7C0, 64'h0, 1'b1);

    // Stall blocks events and writes
    cyc('0, 1'b0, '0, 1'b1, 64'h9000, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    cyc(12'h340, 1'b1, 64'h77, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    rd(12'h341, 64'h1234_5674, 1'b0);
    rd(12'h340, 64'h0, 1'b0);
    rd(12'h300, 64'h1888, 1'b0);

    // Read returns pre-write value in the write cycle
    cyc(12'h340, 1'b1, 64'hABCD, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 1'b0, 1'b0, '0);
    rd(12'h340, 64'hABCD, 1'b0);

    // Reset mid-operation kills the pending redirect and all state
    cyc('0, 1'b0, '0, 1'b1, 64'h40, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    rstn = 1'b0;
    idle();
    #2 rstn = 1'b1;
    idle();
    rd(12'h341, 64'h0, 1'b0);
    rd(12'h340, 64'h0, 1'b0);
    rd(12'h300, 64'h1800, 1'b0);
    rd(12'h305, 64'h1234, 1'b0);
    rd(12'h342, 64'h0, 1'b0);

`ifdef CSR_COUNTERS_EN
    wr(12'hB00, 64'd100);
    cyc(12'hB02, 1'b1, ONES, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 1'b0, 1'b0, '0);
    rd(12'hB00, 64'd101, 1'b0);
    cyc(12'hB02, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, ONES, 1'b0, 1'b0, '0);
    rd(12'hB02, 64'h0, 1'b0);
    cyc(12'hB02, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0, 1'b0, 1'b0, '0);
    rd(12'hB00, 64'd105, 1'b0);
    rd(12'hB02, 64'h0, 1'b0);
    cyc(12'hB02, 1'b1, 64'h5, 1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 64'h1234);
    rd(12'hB02, 64'h1, 1'b0);
`else
    rd(12'hB00, 64'h0, 1'b0);
    wr(12'hB02, 64'h5);
    rd(12'hB02, 64'h0, 1'b0);
    rd(12'hB00, 64'h0, 1'b0);
`endif

    idle();
    @(negedge clk); #1;
    tests++;
    if (rvq.size() != 0 || rdq.size() != 0) begin
      fails++;
      $display("FAIL drain: rvq=%0d rdq=%0d left, want 0 0", rvq.size(), rdq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
